// File: rtl/frame_generator_if.sv
// Command, payload and framed-stream signals of frame_generator, bundled as one interface.
interface frame_generator_if;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [7:0]  cmd_channel;
   logic [3:0]  cmd_len;
   logic        cmd_err;
   logic        pay_vld;
   logic        pay_rdy;
   logic [15:0] pay_data;
   logic [15:0] data_out;
   logic        data_out_vld;
   logic        busy;
   logic        done;

   modport master (
      output cmd_vld, cmd_channel, cmd_len, pay_vld, pay_data,
      input  cmd_rdy, cmd_err, pay_rdy, data_out, data_out_vld, busy, done
   );

   modport slave (
      input  cmd_vld, cmd_channel, cmd_len, pay_vld, pay_data,
      output cmd_rdy, cmd_err, pay_rdy, data_out, data_out_vld, busy, done
   );
endinterface

// File: rtl/frame_generator.sv
// Buffers up to 8 payload words, then emits E0E0 header, channel word, payload, CRC-16/XMODEM
// and 0E0E trailer. Define FRAME_GEN_HDR_PAD_EN for a third E0E0 header word.
module frame_generator (
   input logic              clk_in,
   input logic              rst,
   frame_generator_if.slave bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] HDR  = 3'd2;
   localparam logic [2:0] CH   = 3'd3;
   localparam logic [2:0] PAY  = 3'd4;
   localparam logic [2:0] CRC  = 3'd5;
   localparam logic [2:0] TRL  = 3'd6;

`ifdef FRAME_GEN_HDR_PAD_EN
   localparam logic [3:0] HDR_LAST = 4'd2;
`else
   localparam logic [3:0] HDR_LAST = 4'd1;
`endif

   localparam logic [15:0] HDR_WORD = 16'hE0E0;
   localparam logic [15:0] TRL_WORD = 16'h0E0E;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  len_q;
   logic [7:0]  chan_q;
   logic [15:0] crc_q, crc_d;
   logic [15:0] pay_buf_q [8];
   logic [15:0] data_out_q, data_out_d;
   logic        vld_q, vld_d;
   logic        cmd_err_q, cmd_err_d;
   logic        done_q, done_d;

   logic cmd_ok;
   logic cmd_fire;
   logic pay_fire;

   // MSB-first update over one 16-bit word, no reflection.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
      logic [15:0] c;
      c = crc ^ data;
      for (int b = 0; b < 16; b++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   assign cmd_ok   = (bus.cmd_len != 4'd0) && (bus.cmd_len <= 4'd8) && (bus.cmd_channel != 8'd0);
   assign cmd_fire = (state_q == IDLE) && bus.cmd_vld;
   assign pay_fire = (state_q == LOAD) && bus.pay_vld;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      crc_d     = crc_q;
      cmd_err_d = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cmd_vld) begin
               if (cmd_ok) begin
                  state_d = LOAD;
                  idx_d   = 4'd0;
                  crc_d   = 16'h0000;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (bus.pay_vld) begin
               idx_d = idx_q + 4'd1;
               crc_d = crc16_word(crc_q, bus.pay_data);
               if (idx_q + 4'd1 == len_q) begin
                  state_d = HDR;
                  cnt_d   = 4'd0;
               end
            end
         end
         HDR: begin
            if (cnt_q == HDR_LAST) begin
               state_d = CH;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CH: begin
            state_d = PAY;
            cnt_d   = 4'd0;
         end
         PAY: begin
            if (cnt_q == len_q - 4'd1) begin
               state_d = CRC;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CRC: begin
            state_d = TRL;
            cnt_d   = 4'd0;
         end
         TRL: begin
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output word is chosen from the next state so data_out can be a plain register.
   always_comb begin
      data_out_d = 16'h0000;
      vld_d      = 1'b1;
      case (state_d)
         HDR:     data_out_d = HDR_WORD;
         CH:      data_out_d = {8'h00, chan_q};
         PAY:     data_out_d = pay_buf_q[cnt_d[2:0]];
         CRC:     data_out_d = crc_q;
         TRL:     data_out_d = TRL_WORD;
         default: vld_d      = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= 4'd0;
         crc_q      <= 16'h0000;
         data_out_q <= 16'h0000;
         vld_q      <= 1'b0;
         cmd_err_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         crc_q      <= crc_d;
         data_out_q <= data_out_d;
         vld_q      <= vld_d;
         cmd_err_q  <= cmd_err_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         len_q  <= 4'd0;
         chan_q <= 8'd0;
      end else if (cmd_fire && cmd_ok) begin
         len_q  <= bus.cmd_len;
         chan_q <= bus.cmd_channel;
      end
   end

   // Buffer contents survive reset; they are always rewritten before being read.
   always_ff @(posedge clk_in) begin
      if (!rst && pay_fire) begin
         pay_buf_q[idx_q[2:0]] <= bus.pay_data;
      end
   end

   assign bus.cmd_rdy      = (state_q == IDLE);
   assign bus.pay_rdy      = (state_q == LOAD);
   assign bus.busy         = (state_q != IDLE);
   assign bus.cmd_err      = cmd_err_q;
   assign bus.done         = done_q;
   assign bus.data_out     = data_out_q;
   assign bus.data_out_vld = vld_q;

endmodule

// File: doc/frame_generator.md
FRAME_GENERATOR -- requirements
Module: frame_generator

Interface
REQ-001 The module SHALL have the port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have the port cmd_vld, input, 1 bit: frame command valid.
REQ-004 The module SHALL have the port cmd_rdy, output, 1 bit: command accepted when cmd_vld and cmd_rdy are both high.
REQ-005 The module SHALL have the port cmd_channel, input, 8 bits: channel select written into the channel word.
REQ-006 The module SHALL have the port cmd_len, input, 4 bits: payload length in 16-bit words, legal range 1..8.
REQ-007 The module SHALL have the port cmd_err, output, 1 bit: one-cycle pulse when a command is rejected.
REQ-008 The module SHALL have the port pay_vld, input, 1 bit: payload word valid.
REQ-009 The module SHALL have the port pay_rdy, output, 1 bit: payload word accepted when pay_vld and pay_rdy are both high.
REQ-010 The module SHALL have the port pay_data, input, 16 bits: payload word, big-endian, first word first.
REQ-011 The module SHALL have the port data_out, output, 16 bits: framed stream that drives the frame detector's data_in.
REQ-012 The module SHALL have the port data_out_vld, output, 1 bit: high on every cycle that carries a frame word.
REQ-013 The module SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The module SHALL have the port done, output, 1 bit: one-cycle pulse after the last trailer word.

Function
REQ-015 The module SHALL implement a state machine with the states IDLE, LOAD, HDR, CH, PAY, CRC and TRL.
REQ-016 In IDLE, the module SHALL hold cmd_rdy high; cmd_rdy SHALL be low in every other state.
REQ-017 On cmd_vld with cmd_len in 1..8 and cmd_channel nonzero, the module SHALL latch the channel and length and enter LOAD.
REQ-018 On cmd_vld with cmd_len equal to 0, cmd_len greater than 8, or cmd_channel equal to 0, the module SHALL pulse cmd_err for one cycle next cycle, drop the command and remain in IDLE.
REQ-019 In LOAD, the module SHALL hold pay_rdy high and write each accepted word into an 8x16 buffer at an index counter starting at 0.
REQ-020 When the index reaches the latched length, the module SHALL drop pay_rdy and enter HDR on the same edge.
REQ-021 pay_vld gaps during LOAD SHALL stall loading only; the module SHALL NOT produce any output while in LOAD.
REQ-022 The emitted frame SHALL be contiguous, one word per cycle with data_out_vld high throughout, in this order: E0E0, E0E0, optional pad word (REQ-033), {8'h00, channel}, N payload words in buffer order, CRC, 0E0E, 0E0E.
REQ-023 The first header word SHALL appear on data_out in the cycle after the last payload word is accepted.
REQ-024 data_out and data_out_vld SHALL be registered outputs.
REQ-025 When data_out_vld is low, data_out SHALL be 16'h0000.
REQ-026 The CRC SHALL be CRC-16/XMODEM: polynomial 0x1021, init 0x0000, no reflection, no final XOR.
REQ-027 The CRC SHALL be computed MSB-first over the payload words only, with the header, channel word and trailer excluded.
REQ-028 The CRC SHALL be updated as words enter the buffer, so that its value is final before the CRC state is reached.
REQ-029 The module SHALL pulse done for one cycle on the cycle after the second trailer word, and SHALL return to IDLE on that same cycle, re-asserting cmd_rdy.
REQ-030 A new command SHALL NOT be accepted before done.

Reset
REQ-031 When rst is high at a clock edge, the module SHALL enter IDLE, clear the index and the CRC, and drive cmd_rdy=1 and all other outputs (data_out, data_out_vld, pay_rdy, cmd_err, busy, done) to 0, taking effect on that edge.
REQ-032 Reset asserted mid-frame SHALL abort the frame, with no trailer emitted and no done pulse; buffer contents need not be cleared.

Configuration
REQ-033 With the macro FRAME_GEN_HDR_PAD_EN defined, the module SHALL repeat E0E0 once more after the two header words, giving a three-cycle header and a frame length of N+7 cycles.
REQ-034 Without FRAME_GEN_HDR_PAD_EN defined, the header SHALL be two words and the frame length SHALL be N+6 cycles.

Verification
REQ-035 The bench SHALL check: channel 0x01, len 1, payload 0x0001 -> stream E0E0,E0E0,0001,0001,1021,0E0E,0E0E, then a done pulse.
REQ-036 The bench SHALL check: channel 0x02, len 8, all-zero payload -> 8 zero payload words, CRC 0x0000, data_out_vld high for 14 consecutive cycles.
REQ-037 The bench SHALL check: pay_vld toggled 1,0,1,0 during loading of len 4 -> output stream identical to the gap-free case, with the first header word appearing the cycle after the 4th word is accepted.
REQ-038 The bench SHALL check: cmd_len=0, cmd_len=9 and cmd_channel=0x00 -> each gives a one-cycle cmd_err pulse, busy stays 0 and there is no output.
REQ-039 The bench SHALL check: rst pulsed while the 3rd payload word is being output -> all outputs 0 next cycle, no done, and a following frame is correct.
REQ-040 The bench SHALL check: with FRAME_GEN_HDR_PAD_EN defined, len 1, payload 0xA55A -> three E0E0 words precede {00,ch}, the frame is 8 cycles long, and the frame is accepted by frame_detector with crc_err never asserted.
